// File: rtl/phv_queue_dispatcher_if.sv
// PHV dispatcher bus: PHV input handshake, the shared PHV output bus with per-queue
// write strobes, and the per-queue FIFO ready lines.
// Ports: phv_in/phv_in_valid/phv_in_ready (ingress), phv_out/phv_out_valid/phv_fifo_ready (egress).
interface phv_queue_dispatcher_if #(
    parameter int PHV_LEN      = 1024,
    parameter int C_NUM_QUEUES = 4
);
    logic [PHV_LEN-1:0]      phv_in;
    logic                    phv_in_valid;
    logic                    phv_in_ready;
    logic [PHV_LEN-1:0]      phv_out;
    logic [C_NUM_QUEUES-1:0] phv_out_valid;
    logic [C_NUM_QUEUES-1:0] phv_fifo_ready;

    // Environment side: last pipeline stage plus the queue FIFOs.
    modport master (
        output phv_in, phv_in_valid, phv_fifo_ready,
        input  phv_in_ready, phv_out, phv_out_valid
    );

    // Dispatcher side.
    modport slave (
        input  phv_in, phv_in_valid, phv_fifo_ready,
        output phv_in_ready, phv_out, phv_out_valid
    );
endinterface

// File: rtl/phv_queue_dispatcher.sv
// Output scheduler: copies one PHV into every output-queue FIFO named by its queue bitmap,
// one copy per cycle over a shared bus; empty-bitmap PHVs are dropped and counted.
// Ports: axis_clk, aresetn (sync, active-low), bus (slave modport), busy, sent_cnt, drop_cnt.
module phv_queue_dispatcher #(
    parameter int PHV_LEN      = 1024,
    parameter int C_NUM_QUEUES = 4,
    parameter int QBM_OFF      = 141,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 axis_clk,
    input  logic                 aresetn,
    phv_queue_dispatcher_if.slave bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sent_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    logic [C_NUM_QUEUES-1:0] pending;
    logic [C_NUM_QUEUES-1:0] grant_oh;
    logic [C_NUM_QUEUES-1:0] remaining;
    logic [C_NUM_QUEUES-1:0] bitmap;
    logic                    found;

    // Only the low C_NUM_QUEUES bitmap bits name real queues; the rest are ignored.
    assign bitmap = bus.phv_in[QBM_OFF +: C_NUM_QUEUES];

    // Lowest-index queue that still needs a copy and can take it this cycle.
    // Queues that are not ready are simply skipped, so they never block ready ones.
    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        for (int q = 0; q < C_NUM_QUEUES; q++) begin
            if (!found && pending[q] && bus.phv_fifo_ready[q]) begin
                grant_oh[q] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign remaining        = pending & ~grant_oh;
    assign bus.phv_in_ready = (state == IDLE);
    assign busy             = (state == SEND);

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state             <= IDLE;
            pending           <= '0;
            bus.phv_out       <= '0;
            bus.phv_out_valid <= '0;
            sent_cnt          <= '0;
            drop_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // phv_out only moves here, on the same edge the last strobe drops,
                    // so data is stable for every strobe issued from SEND.
                    bus.phv_out_valid <= '0;
                    if (bus.phv_in_valid) begin
                        bus.phv_out <= bus.phv_in;
                        pending     <= bitmap;
                        if (bitmap == '0) begin
                            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    bus.phv_out_valid <= grant_oh;
                    pending           <= remaining;
                    if (found) begin
                        sent_cnt <= sent_cnt + CNT_WIDTH'(1);
                    end
                    // pending is never zero on SEND entry, so this only fires when the
                    // final copy is granted.
                    if (remaining == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phv_queue_dispatcher.sv
module tb_phv_queue_dispatcher;
    localparam int PHV_LEN = 1024;
    localparam int NQ      = 4;
    localparam int QBM_OFF = 141;

    logic        clk;
    logic        aresetn;
    logic        busy;
    logic [31:0] sent_cnt;
    logic [31:0] drop_cnt;

    phv_queue_dispatcher_if #(.PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ)) bus ();

    phv_queue_dispatcher #(
        .PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ), .QBM_OFF(QBM_OFF), .CNT_WIDTH(32)
    ) dut (
        .axis_clk(clk),
        .aresetn (aresetn),
        .bus     (bus),
        .busy    (busy),
        .sent_cnt(sent_cnt),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the PHV being dispatched and the list of queues still owed a copy.
    bit                 m_holding;
    int                 m_rem[$];
    logic [PHV_LEN-1:0] m_data;
    logic [31:0]        m_sent;
    logic [31:0]        m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_phv(input string tag, input logic [PHV_LEN-1:0] obs,
                           input logic [PHV_LEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed[255:0]=%h expected[255:0]=%h", tag, obs[255:0], exp[255:0]);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] mk_phv(input logic [NQ-1:0] bm);
        logic [PHV_LEN-1:0] p;
        for (int i = 0; i < PHV_LEN / 32; i++) p[i*32 +: 32] = $urandom;
        p[QBM_OFF +: NQ] = bm;
        return p;
    endfunction

    // One clock: drive inputs, advance the model, take the edge, check every output.
    task automatic step(input logic vld, input logic [PHV_LEN-1:0] phv,
                        input logic [NQ-1:0] rdy, output bit accepted);
        logic [NQ-1:0] exp_strobe;
        bus.phv_in         = phv;
        bus.phv_in_valid   = vld;
        bus.phv_fifo_ready = rdy;
        chk("in_ready", 32'(bus.phv_in_ready), 32'(!m_holding));
        accepted   = 1'b0;
        exp_strobe = '0;
        if (!m_holding) begin
            if (vld) begin
                accepted = 1'b1;
                m_data   = phv;
                m_rem.delete();
                for (int q = 0; q < NQ; q++) if (phv[QBM_OFF + q]) m_rem.push_back(q);
                if (m_rem.size() == 0) m_drop = m_drop + 1;
                else m_holding = 1'b1;
            end
        end else begin
            for (int i = 0; i < m_rem.size(); i++) begin
                if (rdy[m_rem[i]]) begin
                    exp_strobe[m_rem[i]] = 1'b1;
                    m_rem.delete(i);
                    m_sent = m_sent + 1;
                    break;
                end
            end
            if (m_rem.size() == 0) m_holding = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.phv_out_valid), 32'(exp_strobe));
        chk("busy", 32'(busy), 32'(m_holding));
        chk("sent_cnt", sent_cnt, m_sent);
        chk("drop_cnt", drop_cnt, m_drop);
        chk_phv("phv_out", bus.phv_out, m_data);
    endtask

    task automatic do_reset(input int cycles);
        bus.phv_in_valid = 1'b0;
        aresetn          = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        m_holding = 1'b0;
        m_rem.delete();
        m_data = '0;
        m_sent = '0;
        m_drop = '0;
        chk("rst_out_valid", 32'(bus.phv_out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.phv_in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_sent", sent_cnt, 32'(0));
        chk("rst_drop", drop_cnt, 32'(0));
        chk_phv("rst_phv_out", bus.phv_out, m_data);
        aresetn = 1'b1;
    endtask

    initial begin
        bit                 acc;
        int                 k;
        int                 steps;
        logic [PHV_LEN-1:0] b2b [8];
        logic [PHV_LEN-1:0] idle_phv;

        idle_phv           = mk_phv(4'b0000);
        bus.phv_in         = '0;
        bus.phv_in_valid   = 1'b0;
        bus.phv_fifo_ready = '0;
        aresetn            = 1'b0;
        #2;
        do_reset(3);

        // Unicast to queue 0.
        step(1'b1, mk_phv(4'b0001), 4'b1111, acc);
        chk("uni_accept", 32'(acc), 32'(1));
        repeat (3) step(1'b0, idle_phv, 4'b1111, acc);

        // Multicast 1011: strobes 0001, 0010, 1000 on consecutive cycles.
        step(1'b1, mk_phv(4'b1011), 4'b1111, acc);
        repeat (5) step(1'b0, idle_phv, 4'b1111, acc);

        // Empty bitmap dropped, next PHV taken on the very next cycle.
        step(1'b1, mk_phv(4'b0000), 4'b1111, acc);
        step(1'b1, mk_phv(4'b0100), 4'b1111, acc);
        chk("drop_then_accept", 32'(acc), 32'(1));
        repeat (2) step(1'b0, idle_phv, 4'b1111, acc);

        // Backpressure: only queue 1 ready for 5 cycles, then all ready.
        step(1'b1, mk_phv(4'b0011), 4'b0010, acc);
        repeat (5) step(1'b0, idle_phv, 4'b0010, acc);
        repeat (3) step(1'b0, idle_phv, 4'b1111, acc);

        // Reset while SEND is stalled with 1100 pending.
        step(1'b1, mk_phv(4'b1100), 4'b0000, acc);
        repeat (3) step(1'b0, idle_phv, 4'b0000, acc);
        chk("stall_busy", 32'(busy), 32'(1));
        do_reset(2);
        repeat (4) step(1'b0, idle_phv, 4'b1111, acc);

        // Back-to-back unicast with valid held high: one accept every two cycles.
        for (int i = 0; i < 8; i++) b2b[i] = mk_phv(4'(1 << (i % 4)));
        k     = 0;
        steps = 0;
        while (k < 8 && steps < 64) begin
            step(1'b1, b2b[k], 4'b1111, acc);
            steps++;
            if (acc) k++;
        end
        chk("b2b_accepts", 32'(k), 32'(8));
        chk("b2b_cycles", 32'(steps), 32'(15));
        step(1'b0, idle_phv, 4'b1111, acc);
        chk("b2b_sent", sent_cnt, 32'(8));

        // Randomized traffic with random per-queue backpressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) != 0), mk_phv(4'($urandom_range(0, 15))),
                 4'($urandom_range(0, 15)), acc);
        end
        repeat (20) step(1'b0, idle_phv, 4'b1111, acc);
        chk("final_idle", 32'(bus.phv_in_ready), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
